cpu_step_controller: RTL

Execution sequencer for the single-cycle RISC-V core. It produces a one-cycle `cpu_step` enable that lets the core commit exactly one instruction. The core's PC and register-file/data-memory write ports run on `clk` gated by this enable. Three execution modes are supported: debounced single-step from a push button, free-run at a programmable divided rate, and automatic stop on a PC breakpoint or an `EBREAK` instruction. Status outputs drive the seven-segment, LED and VGA debug path.

---
 rtl/cpu_step_controller_if.sv | 25 ++
 rtl/cpu_step_controller.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/cpu_step_controller_if.sv
// Signal bundle between the step controller and the debug board / core.
// The controller uses the slave view; the board side (or a bench) uses master.
interface cpu_step_controller_if;
  logic        step_btn;
  logic        run_sw;
  logic        bp_en;
  logic [31:0] bp_addr;
  logic [31:0] pc_current;
  logic [31:0] instruction;
  logic        cpu_step;
  logic [1:0]  state;
  logic [1:0]  stop_cause;
  logic        halted;
  logic [31:0] step_count;

  modport master (
    output step_btn, run_sw, bp_en, bp_addr, pc_current, instruction,
    input  cpu_step, state, stop_cause, halted, step_count
  );

  modport slave (
    input  step_btn, run_sw, bp_en, bp_addr, pc_current, instruction,
    output cpu_step, state, stop_cause, halted, step_count
  );
endinterface

// File: rtl/cpu_step_controller.sv
// Execution sequencer for the single-cycle core: debounced single-step,
// divided free-run, and auto-stop on PC breakpoint or EBREAK.
module cpu_step_controller #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CLK_DIV         = 25000000
) (
  input  logic                  clk,
  input  logic                  reset,
  cpu_step_controller_if.slave  bus
);

  localparam logic [31:0]      EBREAK_INSN = 32'h00100073;
  localparam int               DB_W        = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int               DIV_W       = $clog2(CLK_DIV);
  localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    ST_PAUSED  = 2'b00,
    ST_RUN     = 2'b01,
    ST_STOPPED = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE   = 2'b00,
    CAUSE_BP     = 2'b01,
    CAUSE_EBREAK = 2'b10
  } cause_t;

  // Two-flop synchronizers: bit 0 = step button, bit 1 = run switch
  logic [1:0] async_in;
  logic [1:0] meta_reg;
  logic [1:0] sync_reg;
  logic       btn_s;
  logic       run_s;

  assign async_in = {bus.run_sw, bus.step_btn};
  assign btn_s    = sync_reg[0];
  assign run_s    = sync_reg[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_reg <= '0;
      sync_reg <= '0;
    end else begin
      meta_reg <= async_in;
      sync_reg <= meta_reg;
    end
  end

  // Debounce: accept a new button level only after it has differed from the
  // accepted level for DEBOUNCE_CYCLES consecutive cycles.
  logic [DB_W-1:0] db_cnt_reg;
  logic [DB_W-1:0] db_cnt_next;
  logic            btn_db_reg;
  logic            btn_db_next;
  logic            btn_db_prev_reg;
  logic            step_req;

  always_comb begin
    db_cnt_next = '0;
    btn_db_next = btn_db_reg;
    if (btn_s != btn_db_reg) begin
      if (db_cnt_reg == DB_LAST) begin
        btn_db_next = ~btn_db_reg;
      end else begin
        db_cnt_next = db_cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      db_cnt_reg      <= '0;
      btn_db_reg      <= 1'b0;
      btn_db_prev_reg <= 1'b0;
    end else begin
      db_cnt_reg      <= db_cnt_next;
      btn_db_reg      <= btn_db_next;
      btn_db_prev_reg <= btn_db_reg;
    end
  end

  assign step_req = btn_db_reg & ~btn_db_prev_reg;

  // Sequencer state
  state_t           state_reg;
  state_t           state_next;
  cause_t           cause_reg;
  cause_t           cause_next;
  logic [DIV_W-1:0] div_cnt_reg;
  logic [DIV_W-1:0] div_cnt_next;
  logic             first_tick_reg;
  logic             first_tick_next;
  logic             cpu_step_reg;
  logic             cpu_step_next;
  logic [31:0]      step_count_reg;
  logic [31:0]      step_count_next;
  logic             halted;
  logic             tick;
  logic             bp_hit;

  assign halted = (bus.instruction == EBREAK_INSN);
  assign tick   = (div_cnt_reg == DIV_LAST);
  assign bp_hit = bus.bp_en && (bus.pc_current == bus.bp_addr);

  always_comb begin
    state_next      = state_reg;
    cause_next      = cause_reg;
    div_cnt_next    = div_cnt_reg;
    first_tick_next = first_tick_reg;
    cpu_step_next   = 1'b0;

    case (state_reg)
      ST_PAUSED: begin
        if (run_s) begin
          state_next      = ST_RUN;
          div_cnt_next    = '0;
          first_tick_next = 1'b1;
        end else if (step_req && !halted) begin
          cpu_step_next = 1'b1;
        end
      end

      ST_RUN: begin
        if (!run_s) begin
          // Leaving RUN wins over a coincident tick: no pulse.
          state_next = ST_PAUSED;
        end else begin
          div_cnt_next = tick ? '0 : div_cnt_reg + 1'b1;
          if (tick) begin
            // Clearing first_tick lets a resume step past the breakpoint PC.
            first_tick_next = 1'b0;
            if (halted) begin
              state_next = ST_STOPPED;
              cause_next = CAUSE_EBREAK;
            end else if (bp_hit && !first_tick_reg) begin
              state_next = ST_STOPPED;
              cause_next = CAUSE_BP;
            end else begin
              cpu_step_next = 1'b1;
            end
          end
        end
      end

      ST_STOPPED: begin
        if (!run_s) begin
          state_next = ST_PAUSED;
          cause_next = CAUSE_NONE;
        end
      end

      default: begin
        state_next = ST_PAUSED;
        cause_next = CAUSE_NONE;
      end
    endcase
  end

  assign step_count_next = step_count_reg + {31'd0, cpu_step_reg};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ST_PAUSED;
      cause_reg      <= CAUSE_NONE;
      div_cnt_reg    <= '0;
      first_tick_reg <= 1'b0;
      cpu_step_reg   <= 1'b0;
      step_count_reg <= '0;
    end else begin
      state_reg      <= state_next;
      cause_reg      <= cause_next;
      div_cnt_reg    <= div_cnt_next;
      first_tick_reg <= first_tick_next;
      cpu_step_reg   <= cpu_step_next;
      step_count_reg <= step_count_next;
    end
  end

  assign bus.cpu_step   = cpu_step_reg;
  assign bus.state      = state_reg;
  assign bus.stop_cause = cause_reg;
  assign bus.halted     = halted;
  assign bus.step_count = step_count_reg;

endmodule
